// File: rtl/majority_serial_ctrl_if.sv
// ---------------------------------------------------------------------------
// majority_serial_ctrl_if
//
// This interface bundles the handshake and bus signals of
// majority_serial_ctrl. The word request and the result use separate
// valid/ready pairs.
//
// Signals:
//   in_valid   producer presents a word on data
//   in_ready   evaluator can accept a word (IDLE only)
//   data       N-bit word to evaluate
//   out_valid  result available, held until consumed
//   out_ready  consumer accepts the result
//   y          1 when popcount(word) >= Majority
//   cycles     number of bits scanned to reach the decision
//
// Modports:
//   master  producer/consumer side (drives in_valid, data, out_ready)
//   slave   evaluator side
// ---------------------------------------------------------------------------
interface majority_serial_ctrl_if #(
  parameter int unsigned N = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data;
  logic         out_valid;
  logic         out_ready;
  logic         y;
  logic [7:0]   cycles;

  modport master (
    output in_valid,
    output data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  cycles
  );

  modport slave (
    input  in_valid,
    input  data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output cycles
  );
endinterface

// File: rtl/majority_serial_ctrl.sv
// ---------------------------------------------------------------------------
// majority_serial_ctrl
//
// This block is a bit-serial majority evaluator. It accepts one N-bit word and
// scans the word one bit per cycle, LSB first. It stops early once the outcome
// is certain: either enough ones have been seen, or too few bits remain to
// reach the threshold. It also reports how many bits it examined.
//
// Parameters:
//   N         data word width (1..255)
//   Majority  ones threshold for y=1 (1..N)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; aborts any evaluation in progress
//   bus   majority_serial_ctrl_if.slave (in_valid/in_ready/data,
//         out_valid/out_ready/y/cycles)
//
// Timing: the word is accepted on edge E0. With a decision after s scan
// cycles, out_valid rises after edge E0+s. The result is held until the edge
// with out_valid && out_ready. The block then returns to IDLE and can accept
// the next word one cycle later.
// ---------------------------------------------------------------------------
module majority_serial_ctrl #(
  parameter int unsigned N        = 5,
  parameter int unsigned Majority = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  majority_serial_ctrl_if.slave  bus
);

  // cnt holds 0..N. The sum cnt+rem needs one extra bit so it cannot wrap.
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = CW + 1;

  localparam logic [SW-1:0] MAJ  = SW'(Majority);
  localparam logic [7:0]    LAST = 8'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e         state_q, state_d;

  logic [N-1:0]   word_q, word_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     idx_q, idx_d;
  logic           y_q, y_d;
  logic [7:0]     cyc_q, cyc_d;

  logic           accept;
  logic           bit_cur;
  logic [SW-1:0]  cnt_n;
  logic [SW-1:0]  rem;
  logic [SW-1:0]  reach;
  logic           hit_one;
  logic           hit_zero;
  logic           decided;

  // -------------------------------------------------------------------------
  // Decision arithmetic for the bit currently under examination
  // -------------------------------------------------------------------------
  // The captured word shifts right each scan cycle, so bit[idx] is always
  // at position 0.
  always_comb begin
    bit_cur  = word_q[0];
    cnt_n    = {1'b0, cnt_q} + {{CW{1'b0}}, bit_cur};
    // rem is the number of bits still unexamined after this one.
    rem      = SW'(LAST - idx_q);
    reach    = cnt_n + rem;
    hit_one  = (cnt_n >= MAJ);
    hit_zero = !hit_one && (reach < MAJ);
    decided  = hit_one || hit_zero;
  end

  assign accept = (state_q == IDLE) && bus.in_valid;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (decided) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // in_valid is ignored here; a new word waits for IDLE.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  // The result registers are only qualified by out_valid. They keep their
  // last value in IDLE and SCAN.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.y         = y_q;
    bus.cycles    = cyc_q;
  end

  // -------------------------------------------------------------------------
  // Datapath: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    y_d    = y_q;
    cyc_d  = cyc_q;

    if (accept) begin
      word_d = bus.data;
      cnt_d  = '0;
      idx_d  = '0;
    end else if (state_q == SCAN) begin
      if (hit_one) begin
        y_d   = 1'b1;
        cyc_d = idx_q + 8'd1;
      end else if (hit_zero) begin
        y_d   = 1'b0;
        cyc_d = idx_q + 8'd1;
      end else begin
        // No decision yet, so cnt_n < Majority <= N and it fits in CW bits.
        cnt_d  = cnt_n[CW-1:0];
        idx_d  = idx_q + 8'd1;
        word_d = word_q >> 1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      y_q    <= 1'b0;
      cyc_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      y_q    <= y_d;
      cyc_q  <= cyc_d;
    end
  end

endmodule

// File: doc/majority_serial_ctrl.md
# majority_serial_ctrl

Sequential, bit-serial majority evaluator with a valid/ready handshake on both sides. It accepts one N-bit word, scans it one bit per cycle LSB-first, and terminates early once the majority outcome is decided. It sits between a requesting stage and a consumer, and replaces the combinational majority count where area matters more than latency. It also reports how many bits were examined, so throughput can be profiled.

## Interface
- N, 5: data word width; legal range 1..255.
- Majority, 3: ones threshold for y=1; legal range 1..N.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  producer presents a word on data.
- in_ready  output  1  block can accept a word; high only in IDLE.
- data  input  N  word to evaluate; sampled only on the accept edge.
- out_valid  output  1  result available; held until consumed.
- out_ready  input  1  consumer accepts the result.
- y  output  1  1 when the number of ones in the word is >= Majority.
- cycles  output  8  number of bits scanned to reach the decision (1..N).

## Operation
- FSM states: IDLE, SCAN, DONE. Reset puts the FSM in IDLE.
- Internal registers:
  - captured word shift register, N bits.
  - ones count cnt, width $clog2(N+1).
  - bit index idx, width 8.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture data, clear cnt=0 and idx=0, go to SCAN.
- SCAN: each cycle examine captured bit[idx].
  - cnt_n = cnt + bit[idx].
  - rem = N-1-idx, the bits still unexamined after this one.
  - Evaluate in priority order:
    - If cnt_n >= Majority: y<=1, cycles<=idx+1, go to DONE.
    - Else if cnt_n + rem < Majority: y<=0, cycles<=idx+1, go to DONE.
    - Else cnt<=cnt_n, idx<=idx+1, stay in SCAN.
  - With 1<=Majority<=N, a decision is always reached at or before idx=N-1. At idx=N-1, rem=0, so one of the two rules must fire.
- DONE:
  - out_valid=1; y and cycles are held stable.
  - On out_ready: go to IDLE.
- Input stability:
  - data and in_valid are ignored outside IDLE.
  - Changes on data after the accept edge have no effect on the result.
- Arithmetic:
  - cnt + rem is computed at width $clog2(N+1)+1, so it cannot overflow.
  - Comparisons are unsigned.
- Reset mid-operation (SCAN or DONE) aborts the evaluation: no out_valid pulse, the result is discarded, and the FSM returns to IDLE.

## Timing
- Reset values of registered outputs: out_valid=0, y=0, cycles=0. in_ready is decoded from state, so it reads 1 in the cycle after the reset edge.
- Accept occurs on edge E0.
  - If the decision takes s scan cycles, SCAN occupies the cycles following E0.
  - out_valid rises after edge E0+s.
  - Latency from accept to out_valid is s cycles, with 1 <= s <= N.
- Result handshake completes on the edge with out_valid&&out_ready.
  - out_valid drops and in_ready rises after that edge.
  - There is no same-cycle accept of a new word in DONE. The minimum spacing between accepts is s+2 cycles.
- Backpressure: while out_valid&&!out_ready, y and cycles must not change for any number of cycles.
- y and cycles keep their last value in IDLE and SCAN; only out_valid qualifies them.
- Simultaneous in_valid and out_ready in DONE: the result is consumed, and the new word is not accepted until IDLE.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, y=0, cycles=0. Assert in_valid with rst high: no accept.
- N=5, Majority=3, data=5'b00111: early accept. Expect y=1, cycles=3, out_valid 3 cycles after accept.
- data=5'b11000: early reject. Expect y=0, cycles=3, since 0 ones plus 2 remaining is less than 3.
- data=5'b10101 then data=5'b01010, back to back: full scans.
  - First word: y=1, cycles=5.
  - Second word: y=0, cycles=5.
  - Second accept occurs no earlier than 1 cycle after the first result handshake.
- Backpressure: hold out_ready=0 for 10 cycles with data=5'b11111.
  - Expect y=1 and cycles=3 stable throughout.
  - in_ready=0 throughout; toggling data or in_valid has no effect.
  - Expect exactly one result when out_ready rises.
- Reset mid-SCAN: accept 5'b10101, assert rst on the 2nd scan cycle.
  - Expect no out_valid and in_ready=1 after reset.
  - A following word 5'b00111 yields y=1, cycles=3 normally.
